output_pipeline: RTL

//  Parallel-in, serial-out counterpart to the input pipeline: accepts a DEPTH-word frame in one

---
 rtl/output_pipeline_pkg.sv | 23 ++
 rtl/output_pipeline_ctrl.sv | 92 +++++++++
 rtl/output_pipeline.sv | 101 ++++++++++
 3 files changed

// File: rtl/output_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// output_pipeline_pkg
//   Shared types and helpers for the output pipeline slice.
//   Contents:
//     state_t  - two-state controller encoding (IDLE, SHIFT)
//     cnt_w()  - word-counter width for a given frame depth
// ---------------------------------------------------------------------------
package output_pipeline_pkg;

  // IDLE: no frame in flight, out_valid low.
  // SHIFT: a frame word is being presented on out_stream.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width needed to index DEPTH words. Never returns zero, so a
  // degenerate depth still yields a legal vector.
  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : output_pipeline_pkg

// File: rtl/output_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// output_pipeline_ctrl
//   Control path of the output pipeline: IDLE/SHIFT state machine, word
//   counter, handshake and datapath strobes.
//
//   Ports:
//     clk         in   rising-edge clock
//     reset_n     in   asynchronous active-low reset
//     clk_ena     in   advance strobe shared with the downstream consumer
//     load_valid  in   frame offered by the producer
//     load_ready  out  frame can be accepted this cycle (combinational)
//     accept      out  load_valid & load_ready, loads the shift register
//     shift_en    out  move to the next word of the current frame
//     clear_en    out  last word consumed with no follow-on frame
//     out_valid   out  a frame word is on the output
//     out_last    out  the final word of the frame is on the output
// ---------------------------------------------------------------------------
module output_pipeline_ctrl
  import output_pipeline_pkg::*;
#(
  parameter int DEPTH = 35,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_ena,
  input  logic load_valid,
  output logic load_ready,
  output logic accept,
  output logic shift_en,
  output logic clear_en,
  output logic out_valid,
  output logic out_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last   = (cnt == LAST_IDX);
  assign out_valid = (state == SHIFT);
  assign out_last  = out_valid & at_last;

  // A new frame may enter either from idle, or in the very cycle the final
  // word of the current frame is consumed, which is what gives back-to-back
  // frames without a bubble. While stalled (clk_ena low) nothing is taken.
  assign load_ready = (state == IDLE) | (out_last & clk_ena);
  assign accept     = load_valid & load_ready;

  // Datapath strobes are mutually exclusive: accept wins at the frame
  // boundary, otherwise the consumed last word empties the register.
  assign shift_en = out_valid & clk_ena & ~at_last;
  assign clear_en = out_last & clk_ena & ~accept;

  // State machine and word counter. In IDLE the advance strobe is ignored,
  // so the first word appears one clock after accept regardless of clk_ena.
  // The counter stops at DEPTH-1 and restarts only on a fresh frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (clk_ena) begin
            if (at_last) begin
              cnt <= '0;
              if (!accept) begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : output_pipeline_ctrl

// File: rtl/output_pipeline.sv
// ---------------------------------------------------------------------------
// output_pipeline
//   Parallel-in, serial-out frame streamer. Accepts a DEPTH-word frame in a
//   single valid/ready handshake and presents it one WIDTH-bit word per
//   clk_ena-qualified cycle, word 0 first, to a downstream input pipeline.
//
//   Ports:
//     clk         in   rising-edge clock
//     reset_n     in   asynchronous active-low reset
//     clk_ena     in   advance strobe shared with the downstream consumer
//     load_valid  in   frame offered
//     load_ready  out  frame can be accepted this cycle (combinational)
//     load_data   in   frame, word k = load_data[k*WIDTH +: WIDTH]
//     out_stream  out  current word (registered), 0 when idle
//     out_valid   out  out_stream holds a frame word
//     out_last    out  out_stream holds word DEPTH-1
//     out_parity  out  only with OUTPUT_PIPELINE_PARITY_EN defined:
//                      registered ^out_stream while valid, 0 otherwise
//     busy        out  frame in flight (same as out_valid)
//
//   Build option: define OUTPUT_PIPELINE_PARITY_EN to add out_parity.
// ---------------------------------------------------------------------------
module output_pipeline
  import output_pipeline_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 35
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_ena,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  output logic [WIDTH-1:0]       out_stream,
  output logic                   out_valid,
  output logic                   out_last,
`ifdef OUTPUT_PIPELINE_PARITY_EN
  output logic                   out_parity,
`endif
  output logic                   busy
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic                   accept;
  logic                   shift_en;
  logic                   clear_en;
  logic [WIDTH*DEPTH-1:0] shreg;

  output_pipeline_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_ena    (clk_ena),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .accept     (accept),
    .shift_en   (shift_en),
    .clear_en   (clear_en),
    .out_valid  (out_valid),
    .out_last   (out_last)
  );

  // Word 0 sits in the low slice, so out_stream is simply the bottom of the
  // register. Shifting down with zero fill means the register is all zero
  // by the time the last word is consumed; clear_en makes that explicit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= load_data;
    end else if (shift_en) begin
      shreg <= shreg >> WIDTH;
    end else if (clear_en) begin
      shreg <= '0;
    end
  end

  assign out_stream = shreg[WIDTH-1:0];
  assign busy       = out_valid;

`ifdef OUTPUT_PIPELINE_PARITY_EN
  // Parity is computed from the word about to be presented so that it is
  // registered alongside out_stream rather than derived from it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= ^load_data[WIDTH-1:0];
    end else if (shift_en) begin
      out_parity <= ^shreg[2*WIDTH-1:WIDTH];
    end else if (clear_en) begin
      out_parity <= 1'b0;
    end
  end
`endif

endmodule : output_pipeline
